// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared constants and state encoding for the J1 PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH = 13;
    localparam int c_RESET_VECTOR       = 0;
    localparam int c_IRQ_VECTOR         = 2;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        IRQ_ENTRY = 2'd2
    } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module      : pc_next_mux
// Description : Priority select of the next fetch address (stall > irq >
//               return > jump > sequential).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_mux
    import pc_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] IRQ_ADDR   = ADDR_WIDTH'(c_IRQ_VECTOR)
) (
    input  logic                  stall,
    input  logic                  irq_take,
    input  logic                  ret_req,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] pc_plus1,
    input  logic [ADDR_WIDTH-1:0] ret_addr,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] next,
    output logic [ADDR_WIDTH-1:0] alt_next,
    output logic                  redirect
);

    always_comb begin
        // alt_next is what would be fetched if no interrupt intervened
        alt_next = pc_plus1;
        if (ret_req) begin
            alt_next = ret_addr;
        end else if (jump_req) begin
            alt_next = jump_target;
        end

        next     = alt_next;
        redirect = ret_req | jump_req;

        if (stall) begin
            next     = pc;
            redirect = 1'b0;
        end else if (irq_take) begin
            next     = IRQ_ADDR;
            redirect = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program-counter stage; drives memory port A with the next
//               fetch address. Optional interrupt entry under PC_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_DEFAULT_ADDR_WIDTH,
    parameter int RESET_VECTOR = c_RESET_VECTOR,
    parameter int IRQ_VECTOR   = c_IRQ_VECTOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  ret_req,
    input  logic [ADDR_WIDTH-1:0] ret_addr,
    input  logic                  irq_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus1,
    output logic                  jump_flag,
    output logic                  inst_valid,
    output logic                  irq_ack,
    output logic [ADDR_WIDTH-1:0] irq_ret_pc
);

    localparam logic [ADDR_WIDTH-1:0] c_RST_ADDR = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] c_IRQ_ADDR = ADDR_WIDTH'(IRQ_VECTOR);

    pc_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_jump_flag;
    logic                  r_inst_valid;

    logic [ADDR_WIDTH-1:0] w_next;
    logic [ADDR_WIDTH-1:0] w_alt_next;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic                  w_redirect;
    logic                  w_irq_take;
    logic                  w_run;

    assign w_run      = (r_state != BOOT);
    assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);

    pc_next_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IRQ_ADDR   (c_IRQ_ADDR)
    ) u_next_mux (
        .stall       (stall),
        .irq_take    (w_irq_take),
        .ret_req     (ret_req),
        .jump_req    (jump_req),
        .pc          (r_pc),
        .pc_plus1    (w_pc_plus1),
        .ret_addr    (ret_addr),
        .jump_target (jump_target),
        .next        (w_next),
        .alt_next    (w_alt_next),
        .redirect    (w_redirect)
    );

`ifdef PC_IRQ_EN
    logic                  r_pending;
    logic                  r_in_irq;
    logic                  r_irq_ack;
    logic [ADDR_WIDTH-1:0] r_irq_ret_pc;
    logic                  w_ret_taken;

    // A request arriving this cycle is taken at once if nothing stalls
    assign w_irq_take  = w_run && !stall && !r_in_irq && (r_pending || irq_req);
    assign w_ret_taken = w_run && !stall && ret_req && !w_irq_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 1'b0;
            r_in_irq     <= 1'b0;
            r_irq_ack    <= 1'b0;
            r_irq_ret_pc <= '0;
        end else begin
            r_irq_ack <= w_irq_take;
            if (w_irq_take) begin
                r_pending    <= 1'b0;
                r_in_irq     <= 1'b1;
                r_irq_ret_pc <= w_alt_next;
            end else begin
                if (irq_req && !r_in_irq) begin
                    r_pending <= 1'b1;
                end
                if (r_in_irq && w_ret_taken) begin
                    r_in_irq <= 1'b0;
                end
            end
        end
    end

    assign irq_ack    = r_irq_ack;
    assign irq_ret_pc = r_irq_ret_pc;
`else
    logic w_unused_irq_req;

    assign w_unused_irq_req = irq_req;
    assign w_irq_take       = 1'b0;
    assign irq_ack          = 1'b0;
    assign irq_ret_pc       = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pc         <= c_RST_ADDR;
            r_jump_flag  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state      <= RUN;
                    r_pc         <= c_RST_ADDR;
                    r_jump_flag  <= 1'b0;
                    r_inst_valid <= 1'b1;
                end
                default: begin
                    r_state      <= w_irq_take ? IRQ_ENTRY : RUN;
                    r_pc         <= w_next;
                    r_inst_valid <= 1'b1;
                    if (!stall) begin
                        r_jump_flag <= w_redirect;
                    end
                end
            endcase
        end
    end

    assign mem_addr   = w_run ? w_next : c_RST_ADDR;
    assign pc         = r_pc;
    assign pc_plus1   = w_pc_plus1;
    assign jump_flag  = r_jump_flag;
    assign inst_valid = r_inst_valid;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed and randomized checks of pc_unit against a
//               behavioural next-PC model (PC_IRQ_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam int AW   = 13;
    localparam int MODV = 1 << AW;
    localparam int RV   = 0;
    localparam int IV   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          jump_req = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          ret_req = 1'b0;
    logic [AW-1:0] ret_addr = '0;
    logic          irq_req = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic          jump_flag;
    logic          inst_valid;
    logic          irq_ack;
    logic [AW-1:0] irq_ret_pc;

    pc_unit #(
        .ADDR_WIDTH   (AW),
        .RESET_VECTOR (RV),
        .IRQ_VECTOR   (IV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump_req    (jump_req),
        .jump_target (jump_target),
        .ret_req     (ret_req),
        .ret_addr    (ret_addr),
        .irq_req     (irq_req),
        .mem_addr    (mem_addr),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .jump_flag   (jump_flag),
        .inst_valid  (inst_valid),
        .irq_ack     (irq_ack),
        .irq_ret_pc  (irq_ret_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, integer addresses reduced modulo 2^AW
    bit m_boot;
    int m_pc;
    bit m_jf;
    bit m_iv;
    bit m_ack;
    int m_ret_pc;
    bit m_pend;
    bit m_in_irq;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_take();
`ifdef PC_IRQ_EN
        return !m_boot && !stall && !m_in_irq && (m_pend || irq_req);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        bit take;
        int alt;
        int nxt;
        #1;
        take = m_take();
        alt  = ret_req ? int'(ret_addr) : jump_req ? int'(jump_target) : (m_pc + 1) % MODV;
        if (m_boot)     nxt = RV;
        else if (stall) nxt = m_pc;
        else if (take)  nxt = IV;
        else            nxt = alt;
        chk("mem_addr", int'(mem_addr), nxt);
        @(posedge clk);
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = RV;
            m_jf   = 1'b0;
            m_iv   = 1'b1;
            m_ack  = 1'b0;
`ifdef PC_IRQ_EN
            if (irq_req) m_pend = 1'b1;
`endif
        end else begin
            m_pc  = nxt;
            m_iv  = 1'b1;
            m_ack = take;
            if (!stall) m_jf = take || ret_req || jump_req;
            if (take) begin
                m_ret_pc = alt;
                m_in_irq = 1'b1;
                m_pend   = 1'b0;
            end else begin
`ifdef PC_IRQ_EN
                if (irq_req && !m_in_irq) m_pend = 1'b1;
`endif
                if (m_in_irq && !stall && ret_req) m_in_irq = 1'b0;
            end
        end
        @(negedge clk);
        chk("pc", int'(pc), m_pc);
        chk("pc_plus1", int'(pc_plus1), (m_pc + 1) % MODV);
        chk("jump_flag", int'(jump_flag), int'(m_jf));
        chk("inst_valid", int'(inst_valid), int'(m_iv));
        chk("irq_ack", int'(irq_ack), int'(m_ack));
        chk("irq_ret_pc", int'(irq_ret_pc), m_ret_pc);
    endtask

    task automatic apply(input bit st, input bit jr, input int jt,
                         input bit rr, input int ra, input bit ir);
        stall       = st;
        jump_req    = jr;
        jump_target = AW'(jt);
        ret_req     = rr;
        ret_addr    = AW'(ra);
        irq_req     = ir;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", int'(pc), RV);
        chk("rst_pc_plus1", int'(pc_plus1), RV + 1);
        chk("rst_jump_flag", int'(jump_flag), 0);
        chk("rst_inst_valid", int'(inst_valid), 0);
        chk("rst_irq_ack", int'(irq_ack), 0);
        chk("rst_irq_ret_pc", int'(irq_ret_pc), 0);
        m_boot = 1'b1; m_pc = RV; m_jf = 1'b0; m_iv = 1'b0;
        m_ack = 1'b0; m_ret_pc = 0; m_pend = 1'b0; m_in_irq = 1'b0;
        stall = 1'b0; jump_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Boot sequence: mem_addr=0 in BOOT, then pc=0 valid, then pc=1
        apply(0, 0, 0, 0, 0, 0);
        chk("boot_pc0", int'(pc), 0);
        chk("boot_valid", int'(inst_valid), 1);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0);
        chk("seq_pc5", int'(pc), 5);

        // Jump from pc=5
        apply(0, 1, 'h100, 0, 0, 0);
        chk("jump_pc", int'(pc), 'h100);
        chk("jump_flag_set", int'(jump_flag), 1);
        apply(0, 0, 0, 0, 0, 0);
        chk("jump_seq_pc", int'(pc), 'h101);
        chk("jump_flag_clr", int'(jump_flag), 0);

        // Return beats jump
        apply(0, 1, 'h40, 1, 'h200, 0);
        chk("ret_wins", int'(pc), 'h200);

        // Stall with pending jump
        apply(0, 1, 'h10, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 'h40, 0, 0, 0);
            chk("stall_pc", int'(pc), 'h10);
        end
        apply(0, 1, 'h40, 0, 0, 0);
        chk("stall_then_jump", int'(pc), 'h40);

        // Wrap-around
        apply(0, 1, 'h1FFF, 0, 0, 0);
        chk("wrap_plus1", int'(pc_plus1), 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", int'(pc), 0);
        chk("wrap_flag", int'(jump_flag), 0);

`ifdef PC_IRQ_EN
        apply(0, 1, 'h20, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        chk("irq_entry_pc", int'(pc), IV);
        chk("irq_entry_ack", int'(irq_ack), 1);
        chk("irq_entry_ret", int'(irq_ret_pc), 'h21);
        apply(0, 0, 0, 0, 0, 1);
        chk("irq_masked_pc", int'(pc), IV + 1);
        chk("irq_masked_ack", int'(irq_ack), 0);
        apply(0, 0, 0, 1, 'h21, 0);
        chk("irq_return_pc", int'(pc), 'h21);
`else
        // Interrupt request must have no effect
        apply(0, 0, 0, 0, 0, 1);
        chk("irq_ignored_pc", int'(pc), 1);
`endif

        // Randomized traffic with a mid-run asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset();
            end
            apply($urandom_range(99) < 20,
                  $urandom_range(99) < 25, int'($urandom_range(MODV - 1)),
                  $urandom_range(99) < 10, int'($urandom_range(MODV - 1)),
                  $urandom_range(99) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
